// File: rtl/alu_mul_ctrl_if.sv
// Requester handshake and ALU drive/return signals of the shift-and-add multiply sequencer.
// The sequencer is the slave; the requester/ALU side is the master.
`timescale 1ns/1ps
interface alu_mul_ctrl_if;
  logic       start;
  logic [7:0] mcand;
  logic [7:0] mplier;
  logic       ready;
  logic       done;
  logic [7:0] product;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic       alu_op;
  logic [7:0] alu_result;

  modport slave (
    input  start, mcand, mplier, alu_result,
    output ready, done, product, alu_a, alu_b, alu_op
  );

  modport master (
    output start, mcand, mplier, alu_result,
    input  ready, done, product, alu_a, alu_b, alu_op
  );
endinterface

// File: rtl/alu_mul_ctrl.sv
// 8x8 -> low-byte multiply by shift-and-add, one external ALU operation per clock.
// ADD and SHIFT alternate eight times each, so accept-to-done is a fixed 17 cycles.
`timescale 1ns/1ps
module alu_mul_ctrl (
  input  logic          clk,
  input  logic          rst,
  alu_mul_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t     r_state;
  logic [7:0] r_acc;
  logic [7:0] r_m;
  logic [7:0] r_q;
  logic [7:0] r_product;
  logic [2:0] r_cnt;

  // NOTE: non-blocking assignments keep every register reading pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_acc     <= 8'd0;
      r_m       <= 8'd0;
      r_q       <= 8'd0;
      r_cnt     <= 3'd0;
      r_product <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_m     <= bus.mcand;
            r_q     <= bus.mplier;
            r_acc   <= 8'd0;
            r_cnt   <= 3'd0;
            r_state <= S_ADD;
          end
        end
        S_ADD: begin
          if (r_q[0]) r_acc <= bus.alu_result;
          r_state <= S_SHIFT;
        end
        S_SHIFT: begin
          r_m   <= bus.alu_result;
          r_q   <= {1'b0, r_q[7:1]};
          r_cnt <= r_cnt + 3'd1;
          // acc already holds the final sum: the last ADD precedes this SHIFT.
          if (r_cnt == 3'd7) begin
            r_product <= r_acc;
            r_state   <= S_DONE;
          end else begin
            r_state <= S_ADD;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // ALU drive decodes state and registers only, never alu_result, so no comb loop through the ALU.
  always_comb begin
    // NOTE: defaults first so no path through the case infers a latch.
    bus.alu_a  = 8'd0;
    bus.alu_b  = 8'd0;
    bus.alu_op = 1'b0;
    case (r_state)
      S_ADD: begin
        bus.alu_a  = r_acc;
        bus.alu_b  = r_m;
        bus.alu_op = 1'b0;
      end
      S_SHIFT: begin
        bus.alu_a  = r_m;
        bus.alu_b  = 8'd1;
        bus.alu_op = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.ready   = (r_state == S_IDLE);
  assign bus.done    = (r_state == S_DONE);
  assign bus.product = r_product;
endmodule

// File: tb/tb_alu_mul_ctrl.sv
// Self-checking bench for alu_mul_ctrl: directed cases, busy/ignore, mid-op reset, random multiplies.
// A transaction-level model predicts every output on every falling edge.
`timescale 1ns/1ps
module tb_alu_mul_ctrl;
  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  alu_mul_ctrl_if bus ();

  alu_mul_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // External combinational ALU.
  assign bus.alu_result = bus.alu_op ? (bus.alu_a << bus.alu_b) : (bus.alu_a + bus.alu_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: k = edges since accept (0..16), -1 when idle.
  int         k = -1;
  bit         model_on = 1'b0;
  logic [7:0] ma, mb, exp_prod;

  always @(posedge clk) begin
    if (rst) begin
      k        = -1;
      exp_prod = 8'd0;
      model_on = 1'b1;
    end else if (k < 0) begin
      if (bus.start) begin
        ma = bus.mcand;
        mb = bus.mplier;
        k  = 0;
      end
    end else if (k == 16) begin
      k = -1;
    end else begin
      k++;
      if (k == 16) exp_prod = 8'(int'(ma) * int'(mb));
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      logic [7:0] ea, eb;
      logic       eop;
      int         i;
      ea  = 8'd0;
      eb  = 8'd0;
      eop = 1'b0;
      if (k >= 0 && k <= 15) begin
        i = k / 2;
        if (k % 2 == 0) begin
          ea = 8'(int'(ma) * (int'(mb) & ((1 << i) - 1)));
          eb = 8'(int'(ma) << i);
        end else begin
          eop = 1'b1;
          ea  = 8'(int'(ma) << i);
          eb  = 8'd1;
        end
      end
      check("ready",   32'(bus.ready),   32'(k == -1));
      check("done",    32'(bus.done),    32'(k == 16));
      check("product", 32'(bus.product), 32'(exp_prod));
      check("alu_op",  32'(bus.alu_op),  32'(eop));
      check("alu_a",   32'(bus.alu_a),   32'(ea));
      check("alu_b",   32'(bus.alu_b),   32'(eb));
    end
  end

  // Starts from idle, checks 17-cycle accept-to-done latency and the product literal.
  task automatic run_mul(input logic [7:0] a, input logic [7:0] b, input logic [7:0] exp);
    int n;
    @(posedge clk);
    #1;
    n = 0;
    while (!bus.ready && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("ready_before_start", 32'(bus.ready), 32'd1);
    bus.start  = 1'b1;
    bus.mcand  = a;
    bus.mplier = b;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    bus.mcand  = 8'($urandom);
    bus.mplier = 8'($urandom);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.done && n < 40);
    check("latency", 32'(n), 32'd17);
    check("result",  32'(bus.product), 32'(exp));
  endtask

  int acc_cyc[$];
  int dones;
  int n;
  logic [7:0] first_prod;

  initial begin
    // Reset with start asserted: must be ignored.
    rst        = 1'b1;
    bus.start  = 1'b1;
    bus.mcand  = 8'd3;
    bus.mplier = 8'd5;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready",   32'(bus.ready),   32'd1);
    check("rst_done",    32'(bus.done),    32'd0);
    check("rst_product", 32'(bus.product), 32'd0);
    check("rst_alu_op",  32'(bus.alu_op),  32'd0);
    rst       = 1'b0;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("idle_after_rst", 32'(bus.ready), 32'd1);

    run_mul(8'd3,   8'd5,   8'd15);
    run_mul(8'd255, 8'd255, 8'd1);
    run_mul(8'd16,  8'd16,  8'd0);
    run_mul(8'd51,  8'd78,  8'd138);
    run_mul(8'd10,  8'd26,  8'd4);
    run_mul(8'd200, 8'd0,   8'd0);

    // Busy/ignore: start held high, operands scrambled after accept.
    @(posedge clk);
    #1;
    bus.start  = 1'b1;
    bus.mcand  = 8'd12;
    bus.mplier = 8'd11;
    dones      = 0;
    first_prod = 8'd0;
    for (int i = 0; i < 60 && acc_cyc.size() < 2; i++) begin
      @(negedge clk);
      if (bus.ready && bus.start) acc_cyc.push_back(i);
      if (bus.done) begin
        dones++;
        first_prod = bus.product;
      end
      if (acc_cyc.size() >= 1 && !bus.ready) begin
        bus.mcand  = 8'($urandom);
        bus.mplier = 8'($urandom);
      end
    end
    check("busy_accepts", 32'(acc_cyc.size()), 32'd2);
    if (acc_cyc.size() == 2) check("busy_spacing", 32'(acc_cyc[1] - acc_cyc[0]), 32'd18);
    check("busy_dones",   32'(dones),      32'd1);
    check("busy_product", 32'(first_prod), 32'd132);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.done && n < 40);
    check("busy_second_latency", 32'(n), 32'd17);

    // Reset mid-operation at the 8th edge after accept.
    @(posedge clk);
    #1;
    bus.start  = 1'b1;
    bus.mcand  = 8'd10;
    bus.mplier = 8'd26;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_ready",   32'(bus.ready),   32'd1);
    check("midrst_product", 32'(bus.product), 32'd0);
    check("midrst_done",    32'(bus.done),    32'd0);
    dones = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("midrst_no_done", 32'(dones), 32'd0);
    run_mul(8'd7, 8'd9, 8'd63);

    // Random multiplies with random idle gaps.
    for (int t = 0; t < 30; t++) begin
      logic [7:0] a, b;
      a = 8'($urandom);
      b = 8'($urandom);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      run_mul(a, b, 8'(int'(a) * int'(b)));
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alu_mul_ctrl.md
# alu_mul_ctrl

Multi-cycle sequencer that computes an 8-bit × 8-bit product, low byte, by driving the shared 8-bit add/shift-left ALU. It runs shift-and-add, issuing exactly one ALU operation per clock. It sits between a requester using a start/ready/done handshake and the ALU's a, b, alu_op and result ports. The ALU stays external and purely combinational; this block only sequences it.

## Interface
Parameters: none. Widths are fixed at 8 bits to match the ALU.

- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; accepted on a rising edge where start=1 and ready=1
- mcand  input  8  multiplicand; sampled only at the accept edge
- mplier  input  8  multiplier; sampled only at the accept edge
- ready  output  1  high only in IDLE
- done  output  1  one-cycle pulse, high only in DONE
- product  output  8  registered (mcand*mplier) mod 256; holds until next DONE entry or reset
- alu_a  output  8  ALU operand a
- alu_b  output  8  ALU operand b
- alu_op  output  1  ALU opcode: 0 = a+b, 1 = a<<b
- alu_result  input  8  ALU result (combinational return from ALU)

## Operation
- Internal registers:
  - state ∈ {IDLE, ADD, SHIFT, DONE}
  - acc[7:0], m_reg[7:0], q_reg[7:0]
  - cnt[2:0]
- IDLE: alu_a=0, alu_b=0, alu_op=0.
  - On start: m_reg←mcand, q_reg←mplier, acc←0, cnt←0, state→ADD.
- ADD: alu_a=acc, alu_b=m_reg, alu_op=0.
  - At edge: if q_reg[0]=1, acc←alu_result; else acc unchanged.
  - state→SHIFT.
- SHIFT: alu_a=m_reg, alu_b=8'd1, alu_op=1.
  - At edge: m_reg←alu_result, q_reg←q_reg>>1, cnt←cnt+1.
  - If cnt==7, state→DONE; else state→ADD.
- DONE: alu_a=0, alu_b=0, alu_op=0; done=1.
  - state→IDLE at next edge.
- product←acc on the edge entering DONE.
- Arithmetic is modulo 256. Carries out of bit 7 and bits shifted out of m_reg are discarded; there is no overflow flag.
- Fixed latency: all 8 multiplier bits are processed even if q_reg becomes 0 early. There is no early exit.
- start is ignored while ready=0. mcand and mplier changes after the accept edge have no effect.
- ALU drive outputs are combinational decodes of state and registers only. They must not depend combinationally on alu_result.

## Timing
- Reset: a rising edge with rst=1 forces state=IDLE, acc=m_reg=q_reg=0, cnt=0, product=0.
  - After that edge: ready=1, done=0, alu_a=alu_b=0, alu_op=0.
  - rst takes priority over start; start is ignored on that edge.
- Reset mid-operation: aborts at that edge. No done pulse; product cleared to 0.
- Accept edge E0 → ADD/SHIFT alternate over edges E1..E16 (16 ALU cycles, alu_op pattern 0,1,0,1,...).
  - State becomes DONE after E16; done=1 and the new product are visible in the cycle after E16.
  - IDLE after E17. Earliest next accept is E18 (one ready cycle), so throughput is one result per 18 cycles.
- done is never high for more than one consecutive cycle. done and ready are never high together.

## Test plan
- Reset: hold rst=1 for 2 cycles with start=1, mcand=8'd3 → ready=1, done=0, product=0, alu_op=0. No operation starts after rst drops unless start is still high with ready=1.
- Basic multiply: mcand=3, mplier=5, start pulse → alu_op alternates 0/1 for exactly 16 cycles. Then done=1 for one cycle with product=15; ready returns the cycle after.
- Wrap-around:
  - 255*255 → product=1.
  - 16*16 → product=0.
  - 51*78 → product=138.
  - 10*26 → product=4.
- Zero multiplier: mcand=200, mplier=0 → product=0 with the same 17-cycle accept-to-done latency. acc is never written.
- Busy/ignore: start held high continuously; mcand/mplier changed every cycle after accept → first result uses accept-edge values only. The second accept occurs exactly at E18; no done pulses are missed or duplicated.
- Reset mid-op: rst=1 for one cycle at the 8th cycle after accept of 10*26 → next cycle IDLE, ready=1, product=0, no done. A following 7*9 returns product=63.
